// File: rtl/time_keeper.sv
// BCD 24-hour timekeeping core: 1 Hz prescaler, HH:MM:SS counter, alarm time
// registers, set-mode increments and the self-clearing alarm ring output.
module time_keeper #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int RING_SECS = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] set_mode,
  input  logic       sel_field,
  input  logic       inc_pulse,
  input  logic       stop_pulse,
  input  logic       alarm_en,
  output logic [7:0] clockHour,
  output logic [7:0] clockMin,
  output logic [7:0] clockSec,
  output logic [7:0] alarmHour,
  output logic [7:0] alarmMin,
  output logic       alarm_ring
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [7:0]    RING_LIM = 8'(RING_SECS);

  localparam logic [1:0] MODE_SET_CLK = 2'b01;
  localparam logic [1:0] MODE_SET_ALM = 2'b10;

  // BCD 00..59 increment with wrap
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD 00..23 increment with wrap
  function automatic logic [7:0] inc24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)          r = 8'h00;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                     r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  logic [PW-1:0] pre;
  logic          tick;
  logic          tick_d;
  logic [7:0]    ring_cnt;
  logic          set_clk;
  logic          set_alm;
  logic          ring_start;
  logic          ring_clr;

  assign tick    = (pre == PRE_MAX);
  assign set_clk = (set_mode == MODE_SET_CLK);
  assign set_alm = (set_mode == MODE_SET_ALM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre    <= '0;
      tick_d <= 1'b0;
    end else begin
      tick_d <= tick;
      if (set_clk || tick) pre <= '0;
      else                 pre <= pre + PW'(1);
    end
  end

  // Time of day: set-clock mode freezes seconds at 00 and edits one field
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clockHour <= 8'h00;
      clockMin  <= 8'h00;
      clockSec  <= 8'h00;
    end else if (set_clk) begin
      clockSec <= 8'h00;
      if (inc_pulse) begin
        if (sel_field) clockHour <= inc24(clockHour);
        else           clockMin  <= inc60(clockMin);
      end
    end else if (tick) begin
      clockSec <= inc60(clockSec);
      if (clockSec == 8'h59) begin
        clockMin <= inc60(clockMin);
        if (clockMin == 8'h59) clockHour <= inc24(clockHour);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarmHour <= 8'h00;
      alarmMin  <= 8'h00;
    end else if (set_alm && inc_pulse) begin
      if (sel_field) alarmHour <= inc24(alarmHour);
      else           alarmMin  <= inc60(alarmMin);
    end
  end

  // Compare one cycle after the tick so the freshly updated time is used
  assign ring_start = tick_d && !set_clk && alarm_en &&
                      (clockHour == alarmHour) && (clockMin == alarmMin) &&
                      (clockSec == 8'h00);
  assign ring_clr   = stop_pulse || !alarm_en || set_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_ring <= 1'b0;
      ring_cnt   <= 8'h00;
    end else if (ring_clr) begin
      alarm_ring <= 1'b0;
    end else if (ring_start) begin
      alarm_ring <= 1'b1;
      ring_cnt   <= 8'h00;
    end else if (alarm_ring && tick) begin
      ring_cnt <= ring_cnt + 8'd1;
      if (ring_cnt + 8'd1 == RING_LIM) alarm_ring <= 1'b0;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed steps plus a random phase, all checked
// every cycle against a seconds-of-day reference model.
module tb_time_keeper;
  localparam int TD = 4;
  localparam int RS = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] set_mode;
  logic       sel_field;
  logic       inc_pulse;
  logic       stop_pulse;
  logic       alarm_en;
  logic [7:0] clockHour, clockMin, clockSec, alarmHour, alarmMin;
  logic       alarm_ring;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_pre, m_time, m_alarm, m_cnt;
  bit m_tick_d, m_ring;

  time_keeper #(.TICK_DIV(TD), .RING_SECS(RS)) dut (
    .clk(clk), .rst_n(rst_n), .set_mode(set_mode), .sel_field(sel_field),
    .inc_pulse(inc_pulse), .stop_pulse(stop_pulse), .alarm_en(alarm_en),
    .clockHour(clockHour), .clockMin(clockMin), .clockSec(clockSec),
    .alarmHour(alarmHour), .alarmMin(alarmMin), .alarm_ring(alarm_ring)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pre = 0; m_time = 0; m_alarm = 0; m_cnt = 0; m_tick_d = 0; m_ring = 0;
  endtask

  task automatic model_step();
    int md, h, mi;
    bit t, start, clr;
    if (!rst_n) begin
      model_reset();
      return;
    end
    md    = (set_mode == 2'd3) ? 0 : int'(set_mode);
    t     = (m_pre == TD - 1);
    start = m_tick_d && md != 1 && alarm_en &&
            (m_time / 60 == m_alarm) && (m_time % 60 == 0);
    clr   = stop_pulse || !alarm_en || md == 1;
    m_pre    = (md == 1 || t) ? 0 : m_pre + 1;
    m_tick_d = t;
    if (md == 1) begin
      h  = m_time / 3600;
      mi = (m_time / 60) % 60;
      if (inc_pulse) begin
        if (sel_field) h = (h + 1) % 24;
        else           mi = (mi + 1) % 60;
      end
      m_time = h * 3600 + mi * 60;
    end else if (t) begin
      m_time = (m_time + 1) % 86400;
    end
    if (md == 2 && inc_pulse) begin
      h  = m_alarm / 60;
      mi = m_alarm % 60;
      if (sel_field) h = (h + 1) % 24;
      else           mi = (mi + 1) % 60;
      m_alarm = h * 60 + mi;
    end
    if (clr) m_ring = 0;
    else if (start) begin
      m_ring = 1; m_cnt = 0;
    end else if (m_ring && t) begin
      m_cnt++;
      if (m_cnt == RS) m_ring = 0;
    end
  endtask

  task automatic check_all();
    chk("clockHour", clockHour, bcd(m_time / 3600));
    chk("clockMin",  clockMin,  bcd((m_time / 60) % 60));
    chk("clockSec",  clockSec,  bcd(m_time % 60));
    chk("alarmHour", alarmHour, bcd(m_alarm / 60));
    chk("alarmMin",  alarmMin,  bcd(m_alarm % 60));
    chk("alarm_ring", {7'd0, alarm_ring}, {7'd0, m_ring});
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      inc_pulse = 1'b1; cyc();
      inc_pulse = 1'b0; cyc();
    end
  endtask

  task automatic wait_time(input int target, input string tag);
    int n = 0;
    while (m_time != target && n < 2000) begin
      cyc();
      n++;
    end
    total++;
    assert (m_time == target) else begin
      bad++;
      $error("FAIL %s wait expired observed=%0d expected=%0d", tag, m_time, target);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hr"},  clockHour, 8'h00);
    chk({tag, "_min"}, clockMin,  8'h00);
    chk({tag, "_sec"}, clockSec,  8'h00);
    chk({tag, "_ahr"}, alarmHour, 8'h00);
    chk({tag, "_amin"}, alarmMin, 8'h00);
    chk({tag, "_ring"}, {7'd0, alarm_ring}, 8'h00);
  endtask

  initial begin
    logic [7:0] exp_am, exp_s;
    rst_n = 1'b0; set_mode = 2'b00; sel_field = 1'b0;
    inc_pulse = 1'b0; stop_pulse = 1'b0; alarm_en = 1'b0;
    model_reset();
    cyc(); cyc();
    chk_zero("reset");
    rst_n = 1'b1;

    // first tick on the 4th edge, then 59 more ticks
    repeat (3) cyc();
    chk("sec_before_tick", clockSec, 8'h00);
    cyc();
    chk("sec_first_tick", clockSec, 8'h01);
    repeat (59 * TD) cyc();
    chk("one_min_min", clockMin, 8'h01);
    chk("one_min_sec", clockSec, 8'h00);

    // set clock: hour wrap after 24 pulses, minute wrap to 00
    set_mode = 2'b01; sel_field = 1'b1;
    for (int i = 0; i < 24; i++) begin
      pulses(1);
      if (i == 22) chk("hour_23", clockHour, 8'h23);
    end
    chk("hour_wrap", clockHour, 8'h00);
    sel_field = 1'b0;
    pulses(59);
    chk("min_wrap", clockMin, 8'h00);
    chk("min_wrap_hr", clockHour, 8'h00);
    chk("setclk_sec", clockSec, 8'h00);

    // preload 23:59 and run through midnight
    sel_field = 1'b1; pulses(23);
    sel_field = 1'b0; pulses(59);
    set_mode = 2'b00;
    repeat (59 * TD) cyc();
    chk("pre_mid_hr", clockHour, 8'h23);
    chk("pre_mid_sec", clockSec, 8'h59);
    repeat (TD) cyc();
    chk("midnight_hr", clockHour, 8'h00);
    chk("midnight_min", clockMin, 8'h00);
    chk("midnight_sec", clockSec, 8'h00);

    // 09:59:59 -> 10:00:00
    set_mode = 2'b01;
    sel_field = 1'b1; pulses(9);
    sel_field = 1'b0; pulses(59);
    set_mode = 2'b00;
    repeat (59 * TD) cyc();
    chk("nine_hr", clockHour, 8'h09);
    repeat (TD) cyc();
    chk("ten_hr", clockHour, 8'h10);
    chk("ten_min", clockMin, 8'h00);

    // back to 00:00, alarm at 00:02
    set_mode = 2'b01; sel_field = 1'b1; pulses(14);
    set_mode = 2'b10; sel_field = 1'b0; pulses(2);
    set_mode = 2'b00; alarm_en = 1'b1;
    wait_time(120, "alarm1");
    chk("ring_at_match", {7'd0, alarm_ring}, 8'h00);
    cyc();
    chk("ring_rise", {7'd0, alarm_ring}, 8'h01);
    repeat (10) cyc();
    chk("ring_hold", {7'd0, alarm_ring}, 8'h01);
    cyc();
    chk("ring_fall", {7'd0, alarm_ring}, 8'h00);

    // alarm 00:04, silenced by stop_pulse the cycle after rising
    set_mode = 2'b10; pulses(2);
    set_mode = 2'b00;
    wait_time(240, "alarm2");
    cyc();
    chk("ring2_rise", {7'd0, alarm_ring}, 8'h01);
    stop_pulse = 1'b1; cyc(); stop_pulse = 1'b0;
    chk("ring2_stop", {7'd0, alarm_ring}, 8'h00);

    // alarm 00:06, reset asserted mid-ring and mid-prescale
    set_mode = 2'b10; pulses(2);
    set_mode = 2'b00;
    wait_time(360, "alarm3");
    cyc(); cyc();
    chk("ring3_rise", {7'd0, alarm_ring}, 8'h01);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    model_reset();
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("rst_sec_hold", clockSec, 8'h00);
    cyc();
    chk("rst_first_tick", clockSec, 8'h01);

    // set-alarm increment coincident with a tick
    set_mode = 2'b10; sel_field = 1'b0;
    while (m_pre != TD - 1) cyc();
    exp_am = bcd((m_alarm + 1) % 60);
    exp_s  = bcd((m_time + 1) % 60);
    inc_pulse = 1'b1; cyc(); inc_pulse = 1'b0;
    chk("coinc_amin", alarmMin, exp_am);
    chk("coinc_sec", clockSec, exp_s);

    // random phase checked against the model each cycle
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) set_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
      sel_field  = 1'($urandom_range(0, 1));
      inc_pulse  = ($urandom_range(0, 5) == 0);
      stop_pulse = ($urandom_range(0, 59) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
